// File: rtl/ahb_uram_bridge_if.sv
// ahb_uram_bridge_if: AHB-Lite slave bus plus right-justified SRAM port for the bridge
// Ports (signals): HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY from the AHB master,
// HREADYOUT/HRESP/HRDATA back to it; ram_en/ram_we/ram_addr/ram_wdata to the SRAM,
// ram_rdata from it. slave modport is the bridge side, master modport the environment side.
interface ahb_uram_bridge_if #(parameter int ADDR_W = 8);
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [3:0]        ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, ram_rdata,
    output HREADYOUT, HRESP, HRDATA, ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, ram_rdata,
    input  HREADYOUT, HRESP, HRDATA, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ahb_uram_bridge.sv
// ahb_uram_bridge: AHB-Lite slave driving a byte/half/word right-justified SRAM port
// Ports: clka clock, rsta synchronous active-high reset, bus (slave modport) carrying
// the AHB address/data phase signals and the SRAM size code, strobe, address and data.
module ahb_uram_bridge #(parameter int ADDR_W = 8) (
  input logic              clka,
  input logic              rsta,
  ahb_uram_bridge_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, RD1 = 3'd2, RD2 = 3'd3, ERR1 = 3'd4, ERR2 = 3'd5;
  logic [2:0]        state, state_n;
  logic [3:0]        en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q, wdata, rdata, mask;
  logic [4:0]        sh;
  logic              rdy, cap, bad;
  always_comb begin
    rdy     = state == IDLE || state == WR || state == RD2 || state == ERR2;
    cap     = bus.HSEL & bus.HTRANS[1] & bus.HREADY & rdy;
    bad     = bus.HSIZE > 3'd2 || (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
              (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);
    state_n = state == RD1 ? RD2 : state == ERR1 ? ERR2 : !cap ? IDLE :
              bad ? ERR1 : bus.HWRITE ? WR : RD1;
    // size code doubles as a byte-lane mask for the right-justified side
    mask    = {{8{en_q[3]}}, {8{en_q[2]}}, {8{en_q[1]}}, {8{en_q[0]}}};
    sh      = {addr_q[1:0], 3'b000};
    wdata   = state == WR ? (bus.HWDATA >> sh) & mask : wdata_q;
    rdata   = state == RD2 ? (bus.ram_rdata & mask) << sh : rdata_q;
  end
  assign bus.HREADYOUT = state != RD1 && state != ERR1;
  assign bus.HRESP     = state == ERR1 || state == ERR2;
  // gating with rsta drops a write whose commit edge coincides with reset
  assign bus.ram_we    = state == WR && !rsta;
  assign bus.ram_en    = en_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata;
  assign bus.HRDATA    = rdata;
  always_ff @(posedge clka) begin
    if (rsta) begin
      state   <= IDLE;
      en_q    <= 4'b1111;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      wdata_q <= wdata;
      rdata_q <= rdata;
      if (cap && !bad) begin
        addr_q <= bus.HADDR[ADDR_W-1:0];
        en_q   <= bus.HSIZE == 3'd0 ? 4'b0001 : bus.HSIZE == 3'd1 ? 4'b0011 : 4'b1111;
      end
    end
  end
endmodule

// File: tb/tb_ahb_uram_bridge.sv
// tb_ahb_uram_bridge: randomized and directed checks of ahb_uram_bridge against a byte-level memory model
module tb_ahb_uram_bridge;
  logic clka = 1'b0, rsta = 1'b1, load = 1'b1, hr_block = 1'b0;
  int checks = 0, errors = 0;
  logic [7:0] smem [256];
  logic [7:0] refmem [256];
  ahb_uram_bridge_if #(.ADDR_W(8)) bus();
  ahb_uram_bridge #(.ADDR_W(8)) dut (.clka(clka), .rsta(rsta), .bus(bus));
  always #5 clka = ~clka;
  assign bus.HREADY = hr_block ? 1'b0 : bus.HREADYOUT;
  always @(posedge clka) begin
    if (load) begin
      for (int k = 0; k < 256; k++) smem[k] <= refmem[k];
    end else if (bus.ram_we) begin
      for (int k = 0; k < 4; k++) if (bus.ram_en[k]) smem[bus.ram_addr + 8'(k)] <= bus.ram_wdata[8*k +: 8];
    end
    bus.ram_rdata <= {smem[bus.ram_addr + 8'd3], smem[bus.ram_addr + 8'd2], smem[bus.ram_addr + 8'd1], smem[bus.ram_addr]};
  end
  function automatic logic [31:0] exp_rd(input logic [2:0] sz, input logic [31:0] addr);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < (1 << sz); i++) r[8*(int'(addr[1:0]) + i) +: 8] = refmem[addr[7:0] + 8'(i)];
    return r;
  endfunction
  function automatic logic [31:0] exp_wd(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < (1 << sz); i++) r[8*i +: 8] = data[8*(int'(addr[1:0]) + i) +: 8];
    return r;
  endfunction
  task automatic ref_write(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < (1 << sz); i++) refmem[addr[7:0] + 8'(i)] = data[8*(int'(addr[1:0]) + i) +: 8];
  endtask
  task automatic idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
  endtask
  task automatic ahb_op(input logic w, input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] data,
                        output int waits, output logic r1, output logic rl, output logic [31:0] rd,
                        output logic [3:0] en, output logic [7:0] ra, output logic [31:0] wd, output logic we_any);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = w; bus.HSIZE = sz;
    @(negedge clka);
    idle();
    bus.HWDATA = data;
    #1;
    waits = 0; r1 = bus.HRESP; en = bus.ram_en; ra = bus.ram_addr; wd = bus.ram_wdata; we_any = bus.ram_we;
    while (!bus.HREADYOUT && waits < 8) begin
      @(negedge clka); #1;
      waits++;
      we_any |= bus.ram_we;
    end
    rl = bus.HRESP; rd = bus.HRDATA;
  endtask
  task automatic test_reset();
    idle(); bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HSIZE = 3'd0; bus.HWDATA = '0;
    rsta = 1'b1; load = 1'b1;
    repeat (2) @(negedge clka);
    #1;
    checks++; if (bus.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got=%b exp=1", bus.HREADYOUT); end
    checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp got=%b exp=0", bus.HRESP); end
    checks++; if (bus.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got=%h exp=0", bus.HRDATA); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got=%b exp=0", bus.ram_we); end
    checks++; if (bus.ram_en !== 4'b1111) begin errors++; $display("FAIL reset_ram_en got=%b exp=1111", bus.ram_en); end
    checks++; if (bus.ram_addr !== 8'h0) begin errors++; $display("FAIL reset_ram_addr got=%h exp=0", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_ram_wdata got=%h exp=0", bus.ram_wdata); end
    rsta = 1'b0; load = 1'b0;
    @(negedge clka); #1;
  endtask
  task automatic test_directed();
    int wt; logic r1, rl, we; logic [31:0] rd, wd; logic [3:0] en; logic [7:0] ra;
    ahb_op(1'b1, 3'd2, 32'h10, 32'h11223344, wt, r1, rl, rd, en, ra, wd, we);
    ref_write(3'd2, 32'h10, 32'h11223344);
    checks++; if (wt !== 0 || we !== 1'b1 || en !== 4'b1111 || wd !== 32'h11223344 || rl !== 1'b0)
      begin errors++; $display("FAIL word_write waits=%0d we=%b en=%b wdata=%h resp=%b exp 0/1/1111/11223344/0", wt, we, en, wd, rl); end
    ahb_op(1'b0, 3'd2, 32'h10, 32'h0, wt, r1, rl, rd, en, ra, wd, we);
    checks++; if (wt !== 1 || rd !== 32'h11223344 || rl !== 1'b0)
      begin errors++; $display("FAIL word_read waits=%0d hrdata=%h resp=%b exp 1/11223344/0", wt, rd, rl); end
    ahb_op(1'b1, 3'd0, 32'h13, 32'hAB000000, wt, r1, rl, rd, en, ra, wd, we);
    ref_write(3'd0, 32'h13, 32'hAB000000);
    checks++; if (en !== 4'b0001 || ra !== 8'h13 || wd !== 32'h000000AB || we !== 1'b1)
      begin errors++; $display("FAIL byte_write en=%b addr=%h wdata=%h we=%b exp 0001/13/000000ab/1", en, ra, wd, we); end
    ahb_op(1'b0, 3'd2, 32'h10, 32'h0, wt, r1, rl, rd, en, ra, wd, we);
    checks++; if (rd !== 32'hAB223344) begin errors++; $display("FAIL word_read_merged got=%h exp=ab223344", rd); end
    ahb_op(1'b0, 3'd0, 32'h13, 32'h0, wt, r1, rl, rd, en, ra, wd, we);
    checks++; if (rd !== 32'hAB000000 || wt !== 1) begin errors++; $display("FAIL byte_read got=%h waits=%0d exp=ab000000/1", rd, wt); end
    ahb_op(1'b1, 3'd1, 32'h22, 32'hBEEF0000, wt, r1, rl, rd, en, ra, wd, we);
    ref_write(3'd1, 32'h22, 32'hBEEF0000);
    checks++; if (en !== 4'b0011 || wd !== 32'h0000BEEF || ra !== 8'h22)
      begin errors++; $display("FAIL half_write en=%b wdata=%h addr=%h exp 0011/0000beef/22", en, wd, ra); end
    ahb_op(1'b0, 3'd1, 32'h22, 32'h0, wt, r1, rl, rd, en, ra, wd, we);
    checks++; if (rd !== 32'hBEEF0000) begin errors++; $display("FAIL half_read got=%h exp=beef0000", rd); end
  endtask
  task automatic test_mem_compare(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (smem[i] !== refmem[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL mem_%s differing_bytes=%0d exp=0", tag, bad); end
  endtask
  task automatic test_errors();
    logic [2:0] szs [5] = '{3'd2, 3'd1, 3'd3, 3'd3, 3'd2};
    logic [31:0] ads [5] = '{32'h11, 32'h05, 32'h00, 32'h08, 32'h02};
    logic ws [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int wt; logic r1, rl, we; logic [31:0] rd, wd; logic [3:0] en; logic [7:0] ra;
    for (int i = 0; i < 5; i++) begin
      ahb_op(ws[i], szs[i], ads[i], 32'hDEADBEEF, wt, r1, rl, rd, en, ra, wd, we);
      checks++; if (wt !== 1 || r1 !== 1'b1 || rl !== 1'b1 || we !== 1'b0)
        begin errors++; $display("FAIL error_%0d waits=%0d resp1=%b resp2=%b we=%b exp 1/1/1/0", i, wt, r1, rl, we); end
    end
    idle();
    @(negedge clka); #1;
    test_mem_compare("after_errors");
  endtask
  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2;
    @(negedge clka);
    bus.HADDR = 32'h4; bus.HWDATA = d1; #1;
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h0 || bus.ram_wdata !== d1 || bus.HREADYOUT !== 1'b1)
      begin errors++; $display("FAIL b2b_wr0 we=%b addr=%h wdata=%h rdy=%b exp 1/00/%h/1", bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.HREADYOUT, d1); end
    ref_write(3'd2, 32'h0, d1);
    @(negedge clka);
    bus.HADDR = 32'h0; bus.HWRITE = 1'b0; bus.HWDATA = d2; #1;
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h4 || bus.ram_wdata !== d2)
      begin errors++; $display("FAIL b2b_wr4 we=%b addr=%h wdata=%h exp 1/04/%h", bus.ram_we, bus.ram_addr, bus.ram_wdata, d2); end
    ref_write(3'd2, 32'h4, d2);
    @(negedge clka);
    idle(); #1;
    checks++; if (bus.HREADYOUT !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h0)
      begin errors++; $display("FAIL b2b_rd_wait rdy=%b we=%b addr=%h exp 0/0/00", bus.HREADYOUT, bus.ram_we, bus.ram_addr); end
    @(negedge clka); #1;
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== exp_rd(3'd2, 32'h0))
      begin errors++; $display("FAIL b2b_rd_data rdy=%b hrdata=%h exp 1/%h", bus.HREADYOUT, bus.HRDATA, exp_rd(3'd2, 32'h0)); end
  endtask
  task automatic test_hready_block();
    idle();
    @(negedge clka); #1;
    hr_block = 1'b1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h50; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2; bus.HWDATA = 32'h5A5A5A5A;
    @(negedge clka); #1;
    checks++; if (bus.ram_we !== 1'b0 || bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0)
      begin errors++; $display("FAIL hready_block we=%b rdy=%b resp=%b exp 0/1/0", bus.ram_we, bus.HREADYOUT, bus.HRESP); end
    hr_block = 1'b0;
    idle();
    @(negedge clka); #1;
    test_mem_compare("after_hready_block");
  endtask
  task automatic test_random();
    int wt; logic r1, rl, we, w, ok; logic [31:0] rd, wd, addr, data; logic [3:0] en, een; logic [7:0] ra; logic [2:0] sz;
    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 4) != 0 && sz <= 3'd2) addr = addr & ~((32'd1 << sz) - 32'd1);
      ok = sz <= 3'd2 && (addr & ((32'd1 << sz) - 32'd1)) == 32'd0;
      data = $urandom;
      een = sz == 3'd0 ? 4'b0001 : sz == 3'd1 ? 4'b0011 : 4'b1111;
      ahb_op(w, sz, addr, data, wt, r1, rl, rd, en, ra, wd, we);
      if (!ok) begin
        checks++; if (wt !== 1 || r1 !== 1'b1 || rl !== 1'b1 || we !== 1'b0)
          begin errors++; $display("FAIL rand_err n=%0d waits=%0d resp=%b/%b we=%b exp 1/1/1/0", n, wt, r1, rl, we); end
      end else if (w) begin
        checks++; if (wt !== 0 || rl !== 1'b0 || we !== 1'b1 || en !== een || ra !== addr[7:0] || wd !== exp_wd(sz, addr, data))
          begin errors++; $display("FAIL rand_wr n=%0d waits=%0d resp=%b we=%b en=%b addr=%h wdata=%h exp 0/0/1/%b/%h/%h", n, wt, rl, we, en, ra, wd, een, addr[7:0], exp_wd(sz, addr, data)); end
        ref_write(sz, addr, data);
      end else begin
        checks++; if (wt !== 1 || rl !== 1'b0 || we !== 1'b0 || rd !== exp_rd(sz, addr))
          begin errors++; $display("FAIL rand_rd n=%0d waits=%0d resp=%b we=%b hrdata=%h exp 1/0/0/%h", n, wt, rl, we, rd, exp_rd(sz, addr)); end
      end
    end
    idle();
    @(negedge clka); #1;
    test_mem_compare("after_random");
  endtask
  task automatic test_reset_mid();
    int wt; logic r1, rl, we; logic [31:0] rd, wd; logic [3:0] en; logic [7:0] ra;
    ahb_op(1'b1, 3'd2, 32'h60, 32'h80000001, wt, r1, rl, rd, en, ra, wd, we);
    ref_write(3'd2, 32'h60, 32'h80000001);
    ahb_op(1'b0, 3'd2, 32'h60, 32'h0, wt, r1, rl, rd, en, ra, wd, we);
    checks++; if (rd !== 32'h80000001) begin errors++; $display("FAIL rst_pre_read got=%h exp=80000001", rd); end
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h70; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2;
    @(negedge clka);
    idle(); bus.HWDATA = ~{refmem[8'h73], refmem[8'h72], refmem[8'h71], refmem[8'h70]}; rsta = 1'b1;
    @(negedge clka);
    rsta = 1'b0; #1;
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h0 || bus.ram_we !== 1'b0 || bus.HRESP !== 1'b0)
      begin errors++; $display("FAIL rst_in_wr rdy=%b hrdata=%h we=%b resp=%b exp 1/0/0/0", bus.HREADYOUT, bus.HRDATA, bus.ram_we, bus.HRESP); end
    test_mem_compare("after_rst_wr");
    ahb_op(1'b0, 3'd2, 32'h60, 32'h0, wt, r1, rl, rd, en, ra, wd, we);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h60; bus.HWRITE = 1'b0; bus.HSIZE = 3'd2;
    @(negedge clka);
    idle(); #1;
    checks++; if (bus.HREADYOUT !== 1'b0 || bus.HRDATA !== 32'h80000001)
      begin errors++; $display("FAIL rst_rd1_setup rdy=%b hrdata=%h exp 0/80000001", bus.HREADYOUT, bus.HRDATA); end
    rsta = 1'b1;
    @(negedge clka);
    rsta = 1'b0; #1;
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h0 || bus.ram_we !== 1'b0 || bus.ram_en !== 4'b1111)
      begin errors++; $display("FAIL rst_in_rd1 rdy=%b hrdata=%h we=%b en=%b exp 1/0/0/1111", bus.HREADYOUT, bus.HRDATA, bus.ram_we, bus.ram_en); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) refmem[i] = 8'($urandom);
    @(negedge clka);
    test_reset();
    test_directed();
    test_errors();
    test_back_to_back();
    test_hready_block();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ahb_uram_bridge.md
Name: ahb_uram_bridge

Overview:
- AHB-Lite slave front end that acts as initiator for the byte/half/word sized SRAM port used by the AHB memory models (size code, write strobe, byte address, right-justified data).
- Converts AHB address/data phases into single SRAM accesses.
- Moves write data from its AHB byte lane to the right-justified SRAM format, and read data from the right-justified format back onto the AHB lane.
- Decodes HSIZE into the SRAM size code and returns a two-cycle ERROR response for misaligned or oversized transfers.

Parameters:
- ADDR_W, 8, SRAM byte-address width; ram_addr = HADDR[ADDR_W-1:0].

Ports:
- clka  in  1  clock
- rsta  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  AHB address
- HTRANS  in  2  AHB transfer type; bit1=1 means NONSEQ/SEQ
- HWRITE  in  1  1=write
- HSIZE  in  3  0=byte, 1=half, 2=word, >2 illegal
- HWDATA  in  32  write data, lane-positioned
- HREADY  in  1  bus-level ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data, lane-positioned
- ram_en  out  4  size code: 4'b0001 byte, 4'b0011 half, 4'b1111 word
- ram_we  out  1  write strobe
- ram_addr  out  ADDR_W  byte address
- ram_wdata  out  32  right-justified write data
- ram_rdata  in  32  right-justified read data; registered in SRAM, valid one cycle after address

Behaviour:
- Reset (rsta=1 at a clka edge) sets:
  - state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0
  - ram_we=0, ram_en=4'b1111, ram_addr=0, ram_wdata=0
  - all captured phase registers cleared
- Reset mid-transfer: the pending transfer is dropped; no SRAM write issues.
- Address-phase capture:
  - Capture happens when HSEL & HTRANS[1] & HREADY at a clka edge.
  - Captured fields: HADDR[ADDR_W-1:0], HWRITE, HSIZE.
  - Capture is only possible while HREADYOUT=1, i.e. in IDLE, WR, RD2 or ERR2.
  - IDLE/BUSY transfers, or HSEL=0, are accepted with no SRAM access and return to IDLE.
- Legality check at capture:
  - Error if HSIZE>2.
  - Error if HSIZE=1 and HADDR[0]=1.
  - Error if HSIZE=2 and HADDR[1:0]!=0.
  - An illegal transfer goes to ERR1; no SRAM access is made.
- State machine:
  - IDLE: HREADYOUT=1. Legal write goes to WR, legal read to RD1, illegal to ERR1, otherwise stay.
  - WR (data phase, zero wait): HREADYOUT=1, ram_we=1.
    - ram_en comes from the captured size; ram_addr is the captured address.
    - Byte: ram_wdata = {24'b0, HWDATA[8*a+7:8*a]}, with a = addr[1:0].
    - Half: ram_wdata = {16'b0, HWDATA[16*addr[1]+15:16*addr[1]]}.
    - Word: ram_wdata = HWDATA.
    - Next state is decided by a new capture, as in IDLE.
  - RD1 (one wait state): HREADYOUT=0, ram_we=0, ram_en/ram_addr from captured phase. Always goes to RD2.
  - RD2: HREADYOUT=1.
    - HRDATA = ram_rdata shifted to its lane: byte ram_rdata[7:0] << 8*a; half ram_rdata[15:0] << 16*addr[1]; word unshifted.
    - Non-selected lanes are 0.
    - Next state by new capture.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state by new capture.
- Timing and outputs:
  - HRDATA is held at its last value outside RD2.
  - ram_we is 0 in every state except WR.
  - Outside WR/RD1, ram_en/ram_addr hold their last value.
- Latency: writes take 1 data-phase cycle; reads take 2 (one wait).
- Back-to-back ordering:
  - Write then read to the same address: the SRAM write commits at the end of WR, and the RD1 address in the next cycle sees the new data.
  - Write then write pipelines with no bubble.
- Address wrap: HADDR bits above ADDR_W-1 are ignored; the address aliases modulo 2^ADDR_W.
- HREADY=0 from another slave blocks capture; state is unchanged.

Test Plan:
- Word write HADDR=0x10, HWDATA=0x11223344, then word read 0x10 -> write completes with HREADYOUT=1 and no wait; ram_en=1111, ram_we=1, ram_wdata=0x11223344; read shows one HREADYOUT=0 cycle, then HRDATA=0x11223344, HRESP=0.
- Byte write 0x13 with HWDATA=0xAB000000, then byte read 0x13 -> ram_en=0001, ram_addr=0x13, ram_wdata=0x000000AB; word read 0x10 gives 0xAB223344; byte read gives HRDATA=0xAB000000.
- Half write 0x22 with HWDATA=0xBEEF0000, then half read 0x22 -> ram_en=0011, ram_wdata=0x0000BEEF; HRDATA=0xBEEF0000.
- Illegal transfers: word read at 0x11, half write at 0x05, HSIZE=3 -> each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); ram_we stays 0 and memory is unchanged.
- Back-to-back pipeline: write 0x00, write 0x04, read 0x00 issued with HTRANS=NONSEQ every ready cycle -> two consecutive ram_we pulses, then the read returns the first write's data with exactly one wait state.
- Reset mid-operation: assert rsta during WR and during RD1 -> next cycle state=IDLE, HREADYOUT=1, HRDATA=0, ram_we=0; the interrupted write is not committed.
